// File: rtl/pingpong_buffer.sv
// Double-buffered frame store: the writer fills the back bank while the reader
// scans the front bank; banks exchange only on a reader frame boundary.
module pingpong_buffer #(
  parameter int                DATA_W        = 12,
  parameter int                DEPTH         = 1024,
  parameter int                ADDR_W        = $clog2(DEPTH),
  parameter int                CLEAR_ON_SWAP = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_done,
  output logic              busy,
  output logic              cur_buff
);

  typedef enum logic [1:0] {IDLE, PEND, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [2][DEPTH];

  logic                do_swap, w_ok, r_ok;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  assign busy = (state != IDLE);
  assign w_ok = ({1'b0, w_addr} < DEPTH_C);
  assign r_ok = ({1'b0, r_addr} < DEPTH_C);
  assign do_swap = ((state == IDLE) && swap_req && frame_end) ||
                   ((state == PEND) && frame_end);

  // Single write port per bank, shared between the writer and the clear engine.
  always_comb begin
    wr_en   = w_en && (state == IDLE) && w_ok;
    wr_addr = w_addr;
    wr_data = w_data;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = CLEAR_VAL;
    end
  end

  // Writes always land in the back bank; contents are deliberately not reset.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    always_ff @(posedge clk) begin
      if (wr_en && (cur_buff != 1'(b)))
        mem[b][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_data <= '0;
    else if (r_en)
      r_data <= r_ok ? mem[cur_buff][r_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_buff  <= 1'b0;
      swap_done <= 1'b0;
      clr_cnt   <= '0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        cur_buff <= ~cur_buff;
        clr_cnt  <= '0;
        state    <= (CLEAR_ON_SWAP != 0) ? CLEAR : IDLE;
      end else begin
        case (state)
          IDLE:  if (swap_req) state <= PEND;
          CLEAR: begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
            if (clr_cnt == LAST) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/pingpong_buffer.md
PINGPONG_BUFFER -- requirements
Module: pingpong_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning words per bank (any value >= 2).
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning address width.
REQ-004 The block SHALL have parameter CLEAR_ON_SWAP, default 0, meaning: when 1, the new back bank is filled with CLEAR_VAL after each swap.
REQ-005 The block SHALL have parameter CLEAR_VAL, default 0, meaning fill word (DATA_W bits).
REQ-006 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-007 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-008 Port: w_en  input  1  write strobe, back bank.
REQ-009 Port: w_addr  input  ADDR_W  write address.
REQ-010 Port: w_data  input  DATA_W  write data.
REQ-011 Port: r_en  input  1  read strobe, front bank.
REQ-012 Port: r_addr  input  ADDR_W  read address.
REQ-013 Port: r_data  output  DATA_W  registered read data.
REQ-014 Port: swap_req  input  1  single-cycle request to exchange banks.
REQ-015 Port: frame_end  input  1  reader-side frame boundary strobe; swaps occur only here.
REQ-016 Port: swap_done  output  1  one-cycle pulse after a swap takes effect.
REQ-017 Port: busy  output  1  high while a swap is pending or a clear is running.
REQ-018 Port: cur_buff  output  1  index of the front (read) bank; the back (write) bank is ~cur_buff.

Function
REQ-019 The block SHALL hold two DEPTH x DATA_W banks (bank 0, bank 1), inferable as block RAM.
REQ-020 Write: when w_en=1, busy=0 and w_addr<DEPTH, back[w_addr] SHALL take w_data at that edge.
- A write with busy=1 or w_addr>=DEPTH SHALL be dropped silently.
REQ-021 Read: when r_en=1, r_data SHALL equal front[r_addr] one cycle later, with the bank given by cur_buff at the r_en edge.
- When r_en=0, r_data SHALL hold its value.
- r_addr>=DEPTH SHALL return 0.
REQ-022 FSM states SHALL be IDLE, PEND and CLEAR; busy = (state != IDLE).
REQ-023 IDLE, swap_req=1 with frame_end=0: go to PEND.
REQ-024 IDLE, swap_req=1 with frame_end=1: swap at that edge.
REQ-025 PEND, frame_end=1: swap at that edge.
REQ-026 A swap SHALL:
- toggle cur_buff;
- assert swap_done for exactly the following cycle;
- go to CLEAR if CLEAR_ON_SWAP=1, otherwise to IDLE.
REQ-027 swap_req in PEND or CLEAR SHALL be ignored, with no queuing.
- frame_end in IDLE without swap_req SHALL have no effect.
REQ-028 CLEAR: an ADDR_W counter SHALL start at 0 and write CLEAR_VAL to the new back bank at one address per cycle.
- After address DEPTH-1 the FSM SHALL return to IDLE, so busy is high for exactly DEPTH cycles after the swap edge.
REQ-029 A read in the same cycle as a swap edge SHALL return data from the pre-swap front bank.
REQ-030 CLEAR writes SHALL never target the front bank.
- Reads SHALL remain fully functional during PEND and CLEAR.

Reset
REQ-031 rst_n=0 SHALL immediately force:
- state=IDLE, cur_buff=0, swap_done=0, busy=0, r_data=0;
- clear counter=0;
- any pending swap cancelled.
REQ-032 Bank contents SHALL NOT be reset.
- A reset during CLEAR SHALL leave a partially cleared bank, with no further writes.
REQ-033 After rst_n deasserts, the block SHALL accept writes and requests on the first rising clk edge.

Verification (DATA_W=12, DEPTH=1024)
REQ-034 Write/read: write 0xABC at 0x155 (cur_buff=0), then swap_req+frame_end in the same cycle, then read 0x155 -> r_data=0xABC one cycle after r_en; cur_buff=1; swap_done pulses once.
REQ-035 Deferred swap: swap_req at cycle t, frame_end at t+5 -> busy high t+1..t+5; cur_buff toggles at the t+5 edge; swap_done high at t+6 only; writes at t+2 dropped.
REQ-036 Isolation: with cur_buff=0, write 0x111 at 0x3FF and read 0x3FF -> r_data is the old bank-0 value, not 0x111.
REQ-037 Clear (CLEAR_ON_SWAP=1, CLEAR_VAL=0x5A5): after a swap, busy=1 for exactly 1024 cycles; then a second swap and reads of addresses 0, 0x200, 0x3FF -> 0x5A5 each.
REQ-038 Ignored/reset: swap_req during PEND -> exactly one swap_done; rst_n pulled low at clear cycle 300 -> busy=0, cur_buff=0 immediately; bank addresses >=300 keep prior data.
